// File: rtl/mac_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_feeder_pkg
// Description : Shared definitions for the MAC feeder and the layer
//               controller: FSM state encoding and default widths/latency.
// Revision    : 1.0 - initial release
// ============================================================================
package mac_feeder_pkg;

  localparam int DEF_INPUT_BIT_WIDTH  = 8;
  localparam int DEF_OUTPUT_BIT_WIDTH = 24;
  localparam int DEF_ADDR_WIDTH       = 10;
  localparam int DEF_LEN_WIDTH        = 6;
  localparam int DEF_MAC_LATENCY      = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_OUTPUT = 2'd3
  } feeder_state_e;

endpackage : mac_feeder_pkg
`default_nettype wire

// File: rtl/mac_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : mac_addr_gen
// Description : Holds the neuron/weight base addresses and the product index
//               for one command; drives buffer read enables and addresses
//               and flags the final fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_addr_gen #(
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic [ADDR_WIDTH-1:0] nbase_i,
  input  logic [ADDR_WIDTH-1:0] wbase_i,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] naddr_o,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic                  last_o
);

  logic [ADDR_WIDTH-1:0] nbase_q;
  logic [ADDR_WIDTH-1:0] wbase_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  idx_q;
  logic                  rd_en_q;

  // The final fetch is the one whose index equals len-1 while reading.
  assign last_o  = rd_en_q && (idx_q == (len_q - LEN_WIDTH'(1)));
  assign rd_en_o = rd_en_q;
  // Plain modulo-2^ADDR_WIDTH add gives the buffer wrap-around for free.
  assign naddr_o = nbase_q + ADDR_WIDTH'(idx_q);
  assign waddr_o = wbase_q + ADDR_WIDTH'(idx_q);

  // Latch the command on load, then step the index once per fetch cycle.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      nbase_q <= '0;
      wbase_q <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      rd_en_q <= 1'b0;
    end else if (load_i) begin
      nbase_q <= nbase_i;
      wbase_q <= wbase_i;
      len_q   <= len_i;
      idx_q   <= '0;
      rd_en_q <= (len_i != '0);
    end else if (rd_en_q) begin
      if (last_o) begin
        rd_en_q <= 1'b0;
      end else begin
        idx_q <= idx_q + LEN_WIDTH'(1);
      end
    end
  end

endmodule : mac_addr_gen
`default_nettype wire

// File: rtl/mac_feeder.sv
`default_nettype none
// ============================================================================
// Module      : mac_feeder
// Description : Streams one neuron/weight vector from the on-chip buffers
//               into a MAC, waits out the MAC pipeline, captures the sum and
//               pulses stage_finish to clear the MAC for the next neuron.
//               Build option MAC_FEEDER_RELU_EN: apply ReLU to the captured
//               accumulator (timing unchanged).
// Revision    : 1.0 - initial release
// ============================================================================
module mac_feeder
  import mac_feeder_pkg::*;
#(
  parameter int INPUT_BIT_WIDTH  = DEF_INPUT_BIT_WIDTH,
  parameter int OUTPUT_BIT_WIDTH = DEF_OUTPUT_BIT_WIDTH,
  parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH        = DEF_LEN_WIDTH,
  parameter int MAC_LATENCY      = DEF_MAC_LATENCY
) (
  input  logic                        clk,
  input  logic                        layer_reset,
  input  logic                        start,
  input  logic [LEN_WIDTH-1:0]        cfg_len,
  input  logic [ADDR_WIDTH-1:0]       cfg_nbase,
  input  logic [ADDR_WIDTH-1:0]       cfg_wbase,
  output logic                        busy,
  output logic                        nbuf_rd_en,
  output logic [ADDR_WIDTH-1:0]       nbuf_addr,
  input  logic [INPUT_BIT_WIDTH-1:0]  nbuf_rdata,
  output logic                        wbuf_rd_en,
  output logic [ADDR_WIDTH-1:0]       wbuf_addr,
  input  logic [INPUT_BIT_WIDTH-1:0]  wbuf_rdata,
  output logic                        mac_en,
  output logic [INPUT_BIT_WIDTH-1:0]  neuron,
  output logic [INPUT_BIT_WIDTH-1:0]  weight,
  output logic                        stage_finish,
  input  logic [OUTPUT_BIT_WIDTH-1:0] accumulator,
  output logic                        result_valid,
  input  logic                        result_ready,
  output logic [OUTPUT_BIT_WIDTH-1:0] result
);

  // DRAIN spans buffer latency + operand register + MAC latency; the
  // accumulator is captured on the last DRAIN cycle.
  localparam int                  CNT_W       = $clog2(MAC_LATENCY + 2);
  localparam logic [CNT_W-1:0]    CAPTURE_CNT = CNT_W'(MAC_LATENCY + 1);

  feeder_state_e                 state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          rd_d1_q;
  logic                          mac_en_q;
  logic [INPUT_BIT_WIDTH-1:0]    neuron_q;
  logic [INPUT_BIT_WIDTH-1:0]    weight_q;
  logic                          zero_len_q;
  logic                          stage_finish_q;
  logic [OUTPUT_BIT_WIDTH-1:0]   result_q;

  logic                          w_accept;
  logic                          w_capture;
  logic                          w_rd_en;
  logic                          w_fetch_last;
  logic [OUTPUT_BIT_WIDTH-1:0]   w_capture_val;

  assign w_accept  = (state_q == ST_IDLE) && start;
  assign w_capture = (state_q == ST_DRAIN) && (cnt_q == CAPTURE_CNT);

`ifdef MAC_FEEDER_RELU_EN
  assign w_capture_val = accumulator[OUTPUT_BIT_WIDTH-1] ? '0 : accumulator;
`else
  assign w_capture_val = accumulator;
`endif

  mac_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_addr_gen (
    .clk     (clk),
    .rst_i   (layer_reset),
    .load_i  (w_accept),
    .len_i   (cfg_len),
    .nbase_i (cfg_nbase),
    .wbase_i (cfg_wbase),
    .rd_en_o (w_rd_en),
    .naddr_o (nbuf_addr),
    .waddr_o (wbuf_addr),
    .last_o  (w_fetch_last)
  );

  assign nbuf_rd_en   = w_rd_en;
  assign wbuf_rd_en   = w_rd_en;
  assign busy         = (state_q != ST_IDLE);
  assign result_valid = (state_q == ST_OUTPUT);
  assign mac_en       = mac_en_q;
  assign neuron       = neuron_q;
  assign weight       = weight_q;
  assign stage_finish = stage_finish_q;
  assign result       = result_q;

  // State and drain counter registers.
  always_ff @(posedge clk) begin
    if (layer_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; a zero-length command skips FETCH and pre-loads the
  // counter so only the buffer/operand slots of DRAIN remain.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_len == '0) begin
            state_d = ST_DRAIN;
            cnt_d   = CNT_W'(MAC_LATENCY);
          end else begin
            state_d = ST_FETCH;
            cnt_d   = '0;
          end
        end
      end
      ST_FETCH: begin
        if (w_fetch_last) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CAPTURE_CNT) begin
          state_d = ST_OUTPUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_OUTPUT: begin
        if (result_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand pipeline into the MAC plus result capture and clear pulse.
  always_ff @(posedge clk) begin
    if (layer_reset) begin
      rd_d1_q        <= 1'b0;
      mac_en_q       <= 1'b0;
      neuron_q       <= '0;
      weight_q       <= '0;
      zero_len_q     <= 1'b0;
      stage_finish_q <= 1'b0;
      result_q       <= '0;
    end else begin
      rd_d1_q        <= w_rd_en;
      mac_en_q       <= rd_d1_q;
      stage_finish_q <= w_capture;
      if (rd_d1_q) begin
        neuron_q <= nbuf_rdata;
        weight_q <= wbuf_rdata;
      end
      if (w_accept) begin
        zero_len_q <= (cfg_len == '0);
      end
      if (w_capture) begin
        result_q <= zero_len_q ? '0 : w_capture_val;
      end
    end
  end

endmodule : mac_feeder
`default_nettype wire

// File: tb/tb_mac_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_feeder
// Description : Directed bench for mac_feeder with a 2-cycle MAC model and
//               1-cycle-latency neuron/weight buffer models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_feeder;

  logic        clk = 1'b0;
  logic        layer_reset;
  logic        start;
  logic [5:0]  cfg_len;
  logic [9:0]  cfg_nbase;
  logic [9:0]  cfg_wbase;
  logic        busy;
  logic        nbuf_rd_en;
  logic [9:0]  nbuf_addr;
  logic [7:0]  nbuf_rdata;
  logic        wbuf_rd_en;
  logic [9:0]  wbuf_addr;
  logic [7:0]  wbuf_rdata;
  logic        mac_en;
  logic [7:0]  neuron;
  logic [7:0]  weight;
  logic        stage_finish;
  logic [23:0] accumulator;
  logic        result_valid;
  logic        result_ready;
  logic [23:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] nmem [1024];
  logic [7:0] wmem [1024];

  always #5 clk = ~clk;

  mac_feeder dut (
    .clk          (clk),
    .layer_reset  (layer_reset),
    .start        (start),
    .cfg_len      (cfg_len),
    .cfg_nbase    (cfg_nbase),
    .cfg_wbase    (cfg_wbase),
    .busy         (busy),
    .nbuf_rd_en   (nbuf_rd_en),
    .nbuf_addr    (nbuf_addr),
    .nbuf_rdata   (nbuf_rdata),
    .wbuf_rd_en   (wbuf_rd_en),
    .wbuf_addr    (wbuf_addr),
    .wbuf_rdata   (wbuf_rdata),
    .mac_en       (mac_en),
    .neuron       (neuron),
    .weight       (weight),
    .stage_finish (stage_finish),
    .accumulator  (accumulator),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result)
  );

  // Buffer models: data valid one cycle after the read.
  always_ff @(posedge clk) begin
    if (nbuf_rd_en) nbuf_rdata <= nmem[nbuf_addr];
    if (wbuf_rd_en) wbuf_rdata <= wmem[wbuf_addr];
  end

  // MAC model: product register then accumulate (2 cycles to final value).
  logic signed [15:0] p_q;
  logic               pv_q;
  always_ff @(posedge clk) begin
    if (layer_reset || stage_finish) begin
      p_q         <= '0;
      pv_q        <= 1'b0;
      accumulator <= '0;
    end else begin
      pv_q <= mac_en;
      p_q  <= $signed(neuron) * $signed(weight);
      if (pv_q) accumulator <= accumulator + {{8{p_q[15]}}, p_q};
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One command: start in cycle 0, per-cycle protocol checks, handshake
  // after `hold` cycles of result_valid, then confirm return to idle.
  task automatic run_cmd(input string tag, input int n, input logic [9:0] nb,
                         input logic [9:0] wb, input logic [23:0] exp_res,
                         input int hold, input bit extra_starts);
    int         out_cyc;
    int         k;
    bit         done;
    logic [9:0] ea;
    logic [9:0] eb;
    out_cyc = (n == 0) ? 3 : n + 5;
    tick();
    start = 1'b1; cfg_len = 6'(n); cfg_nbase = nb; cfg_wbase = wb; result_ready = 1'b0;
    @(negedge clk);
    check({tag, " busy c0"}, {31'd0, busy}, 32'd0);
    k = 0;
    done = 1'b0;
    while (!done && k < 200) begin
      tick();
      k++;
      start = extra_starts && (k > out_cyc) && ((k % 2 == 0) || (k == out_cyc + hold));
      result_ready = (k >= out_cyc + hold);
      @(negedge clk);
      check($sformatf("%s busy c%0d", tag, k), {31'd0, busy}, 32'd1);
      check($sformatf("%s rd_en c%0d", tag, k), {31'd0, nbuf_rd_en},
            {31'd0, (k >= 1 && k <= n)});
      if (k >= 1 && k <= n) begin
        ea = nb + 10'(k - 1);
        eb = wb + 10'(k - 1);
        check($sformatf("%s naddr c%0d", tag, k), {22'd0, nbuf_addr}, {22'd0, ea});
        check($sformatf("%s waddr c%0d", tag, k), {22'd0, wbuf_addr}, {22'd0, eb});
      end
      check($sformatf("%s mac_en c%0d", tag, k), {31'd0, mac_en},
            {31'd0, (k >= 3 && k <= n + 2)});
      if (k >= 3 && k <= n + 2) begin
        ea = nb + 10'(k - 3);
        eb = wb + 10'(k - 3);
        check($sformatf("%s neuron c%0d", tag, k), {24'd0, neuron}, {24'd0, nmem[ea]});
        check($sformatf("%s weight c%0d", tag, k), {24'd0, weight}, {24'd0, wmem[eb]});
      end
      check($sformatf("%s stage_finish c%0d", tag, k), {31'd0, stage_finish},
            {31'd0, (k == out_cyc)});
      check($sformatf("%s result_valid c%0d", tag, k), {31'd0, result_valid},
            {31'd0, (k >= out_cyc)});
      if (k >= out_cyc) begin
        check($sformatf("%s result c%0d", tag, k), {8'd0, result}, {8'd0, exp_res});
      end
      if (k == out_cyc + hold) done = 1'b1;
    end
    if (!done) check({tag, " timeout"}, 32'd0, 32'd1);
    tick();
    start = 1'b0;
    result_ready = 1'b0;
    @(negedge clk);
    check({tag, " busy after hs"}, {31'd0, busy}, 32'd0);
    check({tag, " valid after hs"}, {31'd0, result_valid}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      nmem[i] = 8'd0;
      wmem[i] = 8'd0;
    end
    for (int i = 0; i < 4; i++) begin
      nmem[i] = 8'(i + 1);
      wmem[i] = 8'(i + 5);
    end
    nmem[10] = 8'hFD;
    wmem[20] = 8'd4;
    for (int i = 0; i < 36; i++) begin
      nmem[100 + i] = 8'd1;
      wmem[200 + i] = 8'd1;
    end
    nmem[1022] = 8'd3;
    nmem[1023] = 8'd4;
    for (int i = 0; i < 4; i++) wmem[300 + i] = 8'd1;

    layer_reset = 1'b1; start = 1'b0; cfg_len = '0; cfg_nbase = '0; cfg_wbase = '0;
    result_ready = 1'b0;
    tick();
    @(negedge clk);
    check("rst busy",   {31'd0, busy},         32'd0);
    check("rst rd_en",  {31'd0, nbuf_rd_en},   32'd0);
    check("rst naddr",  {22'd0, nbuf_addr},    32'd0);
    check("rst mac_en", {31'd0, mac_en},       32'd0);
    check("rst sf",     {31'd0, stage_finish}, 32'd0);
    check("rst valid",  {31'd0, result_valid}, 32'd0);
    check("rst result", {8'd0, result},        32'd0);
    tick();
    layer_reset = 1'b0;

    // 1*5+2*6+3*7+4*8 = 70
    run_cmd("dot4", 4, 10'd0, 10'd0, 24'd70, 0, 1'b0);
`ifdef MAC_FEEDER_RELU_EN
    run_cmd("neg1", 1, 10'd10, 10'd20, 24'h000000, 0, 1'b0);
`else
    run_cmd("neg1", 1, 10'd10, 10'd20, 24'hFFFFF4, 0, 1'b0);
`endif
    run_cmd("hold5", 4, 10'd0, 10'd0, 24'd70, 5, 1'b1);
    run_cmd("b2b_a", 36, 10'd100, 10'd200, 24'd36, 0, 1'b0);
    run_cmd("b2b_b", 36, 10'd100, 10'd200, 24'd36, 0, 1'b0);
    // 3+4+1+2 = 10, addresses wrap 1022,1023,0,1
    run_cmd("wrap", 4, 10'd1022, 10'd300, 24'd10, 0, 1'b0);
    run_cmd("zero", 0, 10'd5, 10'd5, 24'd0, 0, 1'b0);

    // Abort in FETCH with layer_reset at cycle 2.
    tick();
    start = 1'b1; cfg_len = 6'd4; cfg_nbase = 10'd0; cfg_wbase = 10'd0;
    tick();
    start = 1'b0;
    tick();
    layer_reset = 1'b1;
    @(negedge clk);
    check("abort busy c2", {31'd0, busy}, 32'd1);
    tick();
    layer_reset = 1'b0;
    @(negedge clk);
    check("abort busy",   {31'd0, busy},         32'd0);
    check("abort rd_en",  {31'd0, nbuf_rd_en},   32'd0);
    check("abort wrd_en", {31'd0, wbuf_rd_en},   32'd0);
    check("abort naddr",  {22'd0, nbuf_addr},    32'd0);
    check("abort waddr",  {22'd0, wbuf_addr},    32'd0);
    check("abort mac_en", {31'd0, mac_en},       32'd0);
    check("abort neuron", {24'd0, neuron},       32'd0);
    check("abort weight", {24'd0, weight},       32'd0);
    check("abort sf",     {31'd0, stage_finish}, 32'd0);
    check("abort valid",  {31'd0, result_valid}, 32'd0);
    check("abort result", {8'd0, result},        32'd0);
    run_cmd("after_abort", 4, 10'd0, 10'd0, 24'd70, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule : tb_mac_feeder
`default_nettype wire
